// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: registered state, with select
// and enable outputs decoded combinationally from state, mem_ready, zero and funct.
module multicycle_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       iord,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       rf_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_sel,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  state_t cur, nxt;
  logic   is_store;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b100110) || (f == 6'b100111);
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b100110: return ALU_XOR;
      6'b100111: return ALU_NOR;
      default:   return ALU_ADD;
    endcase
  endfunction

  // lw/sw is resolved in DECODE so MEMADR does not depend on a later opcode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur      <= FETCH;
      is_store <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) is_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = funct_ok(funct) ? EXEC : HALT;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = HALT;
        endcase
      end
      MEMADR: nxt = is_store ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) nxt = MEMWB;
      MEMWB:  nxt = FETCH;
      MEMWR:  if (mem_ready) nxt = FETCH;
      EXEC:   nxt = ALUWB;
      ALUWB:  nxt = FETCH;
      BRANCH: nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
      JUMP:   nxt = FETCH;
      HALT:   nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    rf_we      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_sel    = ALU_ADD;
    pc_src     = 2'd0;
    halted     = 1'b0;
    case (cur)
      FETCH: begin
        alu_src_b = 2'd1;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      DECODE: alu_src_b = 2'd3;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEMRD:  iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        rf_we      = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_sel   = funct_alu(funct);
      end
      ALUWB: begin
        reg_dst = 1'b1;
        rf_we   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = 2'd1;
        pc_we     = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      ADDIWB: rf_we = 1'b1;
      JUMP: begin
        pc_src = 2'd2;
        pc_we  = 1'b1;
      end
      HALT:   halted = 1'b1;
      default: ;
    endcase
    // state is already FETCH under reset; only the enables need suppressing
    if (reset) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mem_we = 1'b0;
      rf_we  = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected output words are queued
// as each cycle's inputs are driven and compared on the following falling edge.
module tb_multicycle_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, iord, mem_we, ir_we, reg_dst, mem_to_reg, rf_we, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_sel, state;
  logic       halted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       tag;
    logic [20:0] w;
  } exp_t;
  exp_t sb[$];

  multicycle_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we), .iord(iord),
    .mem_we(mem_we), .ir_we(ir_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .rf_we(rf_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_sel(alu_sel), .pc_src(pc_src), .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  // {state, pc_we, iord, mem_we, ir_we, reg_dst, mem_to_reg, rf_we,
  //  alu_src_a, alu_src_b, alu_sel, pc_src, halted}
  function automatic logic [20:0] ex(input logic [3:0] st, input logic pw, io, mw, iw,
                                     rd, m2r, rw, asa, input logic [1:0] asb,
                                     input logic [3:0] alu, input logic [1:0] pcs,
                                     input logic h);
    return {st, pw, io, mw, iw, rd, m2r, rw, asa, asb, alu, pcs, h};
  endfunction

  function automatic logic [20:0] w_rst();          return ex(0, 0,0,0,0,0,0,0,0, 1, 0, 0, 0); endfunction
  function automatic logic [20:0] w_f(input logic r); return ex(0, r,0,0,r,0,0,0,0, 1, 0, 0, 0); endfunction
  function automatic logic [20:0] w_d();            return ex(1, 0,0,0,0,0,0,0,0, 3, 0, 0, 0); endfunction
  function automatic logic [20:0] w_ma();           return ex(2, 0,0,0,0,0,0,0,1, 2, 0, 0, 0); endfunction
  function automatic logic [20:0] w_mr();           return ex(3, 0,1,0,0,0,0,0,0, 0, 0, 0, 0); endfunction
  function automatic logic [20:0] w_mwb();          return ex(4, 0,0,0,0,0,1,1,0, 0, 0, 0, 0); endfunction
  function automatic logic [20:0] w_mw();           return ex(5, 0,1,1,0,0,0,0,0, 0, 0, 0, 0); endfunction
  function automatic logic [20:0] w_ex(input logic [3:0] a); return ex(6, 0,0,0,0,0,0,0,1, 0, a, 0, 0); endfunction
  function automatic logic [20:0] w_aw();           return ex(7, 0,0,0,0,1,0,1,0, 0, 0, 0, 0); endfunction
  function automatic logic [20:0] w_br(input logic z); return ex(8, z,0,0,0,0,0,0,1, 0, 1, 1, 0); endfunction
  function automatic logic [20:0] w_ae();           return ex(9, 0,0,0,0,0,0,0,1, 2, 0, 0, 0); endfunction
  function automatic logic [20:0] w_ai();           return ex(10,0,0,0,0,0,0,1,0, 0, 0, 0, 0); endfunction
  function automatic logic [20:0] w_j();            return ex(11,1,0,0,0,0,0,0,0, 0, 0, 2, 0); endfunction
  function automatic logic [20:0] w_h();            return ex(12,0,0,0,0,0,0,0,0, 0, 0, 0, 1); endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {state, pc_we, iord, mem_we, ir_we, reg_dst, mem_to_reg, rf_we,
                    alu_src_a, alu_src_b, alu_sel, pc_src, halted}, e.w);
    end
  end

  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [20:0] w);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    e.tag = tag;
    e.w   = w;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  logic [5:0] r_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111};
  logic [3:0] r_alu   [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6};

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
    @(posedge clock); #1;
    cyc("rst0", 1, 0, w_rst());
    cyc("rst1", 1, 1, w_rst());

    // lw: fetch stall, opcode disturbed in MEMADR, two MEMRD stalls
    reset = 1'b0;
    opcode = 6'b100011;
    cyc("lw_fstall", 0, 0, w_f(0));
    cyc("lw_f", 1, 0, w_f(1));
    cyc("lw_d", 1, 0, w_d());
    opcode = 6'b101011;
    cyc("lw_ma", 1, 0, w_ma());
    cyc("lw_mr0", 0, 1, w_mr());
    cyc("lw_mr1", 0, 0, w_mr());
    cyc("lw_mr2", 1, 0, w_mr());
    cyc("lw_wb", 1, 0, w_mwb());

    // R-type sweep with zero held high (must not matter)
    opcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = r_funct[i];
      cyc("r_f", 1, 1, w_f(1));
      cyc("r_d", 1, 1, w_d());
      cyc("r_ex", 1, 1, w_ex(r_alu[i]));
      cyc("r_wb", 1, 1, w_aw());
    end

    opcode = 6'b000100;
    cyc("beq1_f", 1, 1, w_f(1));
    cyc("beq1_d", 1, 1, w_d());
    cyc("beq1_br", 1, 1, w_br(1));
    cyc("beq0_f", 1, 0, w_f(1));
    cyc("beq0_d", 1, 0, w_d());
    cyc("beq0_br", 1, 0, w_br(0));

    opcode = 6'b001000;
    cyc("addi_f", 1, 0, w_f(1));
    cyc("addi_d", 1, 0, w_d());
    cyc("addi_ex", 1, 0, w_ae());
    cyc("addi_wb", 1, 0, w_ai());

    opcode = 6'b101011;
    cyc("sw_f", 1, 0, w_f(1));
    cyc("sw_d", 1, 0, w_d());
    opcode = 6'b100011;
    cyc("sw_ma", 1, 0, w_ma());
    cyc("sw_mw0", 0, 0, w_mw());
    cyc("sw_mw1", 1, 0, w_mw());

    opcode = 6'b000010;
    cyc("j_f", 1, 0, w_f(1));
    cyc("j_d", 1, 0, w_d());
    cyc("j_j", 1, 0, w_j());

    // reset asserted while a store is stalled in MEMWR
    opcode = 6'b101011;
    cyc("swr_f", 1, 0, w_f(1));
    cyc("swr_d", 1, 0, w_d());
    cyc("swr_ma", 1, 0, w_ma());
    cyc("swr_mw", 0, 0, w_mw());
    reset = 1'b1;
    cyc("swr_rst", 1, 0, w_rst());
    reset = 1'b0;

    opcode = 6'b111111;
    cyc("ill_f", 1, 0, w_f(1));
    cyc("ill_d", 1, 0, w_d());
    for (int i = 0; i < 22; i++) begin
      opcode = 6'($urandom);
      cyc("ill_halt", 1'($urandom), 1'($urandom), w_h());
    end
    reset = 1'b1;
    cyc("ill_rst", 1, 1, w_rst());
    reset = 1'b0;

    opcode = 6'b000000; funct = 6'b101010;
    cyc("illf_f", 1, 0, w_f(1));
    cyc("illf_d", 1, 0, w_d());
    for (int i = 0; i < 3; i++) cyc("illf_halt", 1, 1, w_h());
    reset = 1'b1;
    cyc("illf_rst", 1, 0, w_rst());
    reset = 1'b0;
    cyc("post_f", 1, 0, w_f(1));
    cyc("post_d", 1, 0, w_d());

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain obs=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
